// File: rtl/or1200_ifq_pkg.sv
// Shared constants and the queue entry layout for the or1200 instruction fetch queue.
package or1200_ifq_pkg;

    localparam logic [31:0] IFQ_NOP   = {6'h05, 26'h061_0000};

    localparam logic [3:0]  ITAG_IDLE = 4'h0;
    localparam logic [3:0]  ITAG_BE   = 4'hb;
    localparam logic [3:0]  ITAG_PE   = 4'hc;
    localparam logic [3:0]  ITAG_TE   = 4'hd;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        err;
        logic [3:0]  tag;
    } ifq_entry_t;

endpackage

// File: rtl/or1200_ifq_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy count; head read from storage.
module or1200_ifq_fifo
    import or1200_ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  ifq_entry_t             push_data_i,
    input  logic                   pop_i,
    output ifq_entry_t             head_o,
    output logic                   head_valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    ifq_entry_t    mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop_i & (cnt_q != '0);
    // A push at full is only safe when the head leaves in the same cycle.
    assign do_push = push_i & ((cnt_q != FULL) | do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head_o       = mem_q[rd_q];
    assign head_valid_o = (cnt_q != '0);
    assign count_o      = cnt_q;

endmodule

// File: rtl/or1200_ifq.sv
// Instruction fetch queue: sequential IC requests, in-order response buffering, redirect flush.
// Optional same-cycle response bypass when empty is enabled by defining OR1200_IFQ_BYPASS_EN.
module or1200_ifq
    import or1200_ifq_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ic_req_o,
    output logic [31:0] ic_adr_o,
    input  logic        ic_gnt_i,
    input  logic        ic_rvalid_i,
    input  logic [31:0] ic_dat_i,
    input  logic        ic_err_i,
    input  logic [3:0]  ic_tag_i,
    input  logic        if_freeze,
    output logic [31:0] icpu_dat_o,
    output logic        icpu_ack_o,
    output logic        icpu_err_o,
    output logic [31:0] icpu_adr_o,
    output logic [3:0]  icpu_tag_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_adr_q, rsp_adr_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          halted_q, halted_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_sum;
    logic          grant, accept, bypass, push, pop, head_valid;
    ifq_entry_t    rsp_entry, head;

    // Handshakes: a request transfers when ic_req_o & ic_gnt_i; a response is one
    // ic_rvalid_i pulse in request order; the IF stage takes the head when !if_freeze.
    assign credit_sum = {1'b0, fifo_count} + {1'b0, outst_q};
    assign ic_req_o   = rst & ~halted_q & ~redirect_i & (credit_sum < DEPTH_L);
    assign ic_adr_o   = pc_q;
    assign grant      = ic_req_o & ic_gnt_i;
    assign accept     = ic_rvalid_i & (drop_q == '0) & ~redirect_i;

`ifdef OR1200_IFQ_BYPASS_EN
    assign bypass = accept & ~head_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept & ~(bypass & ~if_freeze);
    assign pop  = head_valid & ~if_freeze & ~redirect_i;

    assign rsp_entry.adr = rsp_adr_q;
    assign rsp_entry.dat = ic_err_i ? IFQ_NOP : ic_dat_i;
    assign rsp_entry.err = ic_err_i;
    assign rsp_entry.tag = ic_tag_i;

    or1200_ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_i),
        .push_i       (push),
        .push_data_i  (rsp_entry),
        .pop_i        (pop),
        .head_o       (head),
        .head_valid_o (head_valid),
        .count_o      (fifo_count)
    );

    always_comb begin
        pc_d      = pc_q;
        rsp_adr_d = rsp_adr_q;
        outst_d   = outst_q + CW'(grant) - CW'(ic_rvalid_i);
        drop_d    = drop_q;
        halted_d  = halted_q;
        if (redirect_i) begin
            pc_d      = redirect_pc_i & ~32'h3;
            rsp_adr_d = redirect_pc_i & ~32'h3;
            // Everything still in flight after this cycle belongs to the old stream.
            drop_d    = outst_d;
            halted_d  = 1'b0;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (accept) begin
                rsp_adr_d = rsp_adr_q + 32'd4;
                if (ic_err_i) begin
                    halted_d = 1'b1;
                end
            end else if (ic_rvalid_i && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            rsp_adr_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rsp_adr_q <= rsp_adr_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        icpu_dat_o = IFQ_NOP;
        icpu_ack_o = 1'b0;
        icpu_err_o = 1'b0;
        icpu_adr_o = pc_q;
        icpu_tag_o = ITAG_IDLE;
        if (head_valid) begin
            icpu_dat_o = head.dat;
            icpu_ack_o = ~head.err;
            icpu_err_o = head.err;
            icpu_adr_o = head.adr;
            icpu_tag_o = head.tag;
        end else if (bypass) begin
            icpu_dat_o = rsp_entry.dat;
            icpu_ack_o = ~rsp_entry.err;
            icpu_err_o = rsp_entry.err;
            icpu_adr_o = rsp_entry.adr;
            icpu_tag_o = rsp_entry.tag;
        end
    end

endmodule

// File: tb/tb_or1200_ifq.sv
// Directed bench for or1200_ifq: IC responder model, expected-entry queue and a consuming monitor.
`timescale 1ns/1ps
module tb_or1200_ifq;
    import or1200_ifq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ic_req_o;
    logic [31:0] ic_adr_o;
    logic        ic_gnt_i = 1'b0;
    logic        ic_rvalid_i = 1'b0;
    logic [31:0] ic_dat_i = '0;
    logic        ic_err_i = 1'b0;
    logic [3:0]  ic_tag_i = '0;
    logic        if_freeze = 1'b0;
    logic [31:0] icpu_dat_o;
    logic        icpu_ack_o;
    logic        icpu_err_o;
    logic [31:0] icpu_adr_o;
    logic [3:0]  icpu_tag_o;

    or1200_ifq dut (
        .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .ic_req_o(ic_req_o), .ic_adr_o(ic_adr_o), .ic_gnt_i(ic_gnt_i),
        .ic_rvalid_i(ic_rvalid_i), .ic_dat_i(ic_dat_i), .ic_err_i(ic_err_i), .ic_tag_i(ic_tag_i),
        .if_freeze(if_freeze), .icpu_dat_o(icpu_dat_o), .icpu_ack_o(icpu_ack_o),
        .icpu_err_o(icpu_err_o), .icpu_adr_o(icpu_adr_o), .icpu_tag_o(icpu_tag_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] adr; int epoch; } req_t;

    req_t        pend_q[$];
    logic [68:0] exp_q[$];
    int          cur_epoch = 0;
    int          total = 0;
    int          bad = 0;
    bit          rsp_en = 1'b0;
    bit          err_on = 1'b0;
    logic [31:0] err_adr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~a ^ 32'h5a5a_0f0f;
    endfunction

    function automatic logic [68:0] make_exp(input logic [31:0] a);
        logic e;
        e = err_on && (a == err_adr);
        return {a, e ? IFQ_NOP : mem_word(a), e, e ? ITAG_PE : ITAG_IDLE};
    endfunction

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // IC responder: answers grants in order one cycle later, expected entries pushed on response.
    initial begin
        req_t r;
        logic e;
        forever begin
            @(negedge clk);
            #1;
            ic_rvalid_i = 1'b0;
            if (rsp_en && pend_q.size() > 0) begin
                e           = err_on && (pend_q[0].adr == err_adr);
                ic_rvalid_i = 1'b1;
                ic_dat_i    = mem_word(pend_q[0].adr);
                ic_err_i    = e;
                ic_tag_i    = e ? ITAG_PE : ITAG_IDLE;
            end
            #2;
            if (!rst) begin
                pend_q.delete();
                exp_q.delete();
            end else begin
                if (ic_rvalid_i) begin
                    r = pend_q.pop_front();
                    if (r.epoch == cur_epoch && !redirect_i) exp_q.push_back(make_exp(r.adr));
                end
                if (ic_req_o && ic_gnt_i) begin
                    r.adr   = ic_adr_o;
                    r.epoch = cur_epoch;
                    pend_q.push_back(r);
                end
                if (redirect_i) begin
                    exp_q.delete();
                    cur_epoch++;
                end
            end
        end
    end

    // Monitor: every entry the IF stage consumes must be the next expected one.
    initial begin
        logic [68:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst && !if_freeze && !redirect_i && (icpu_ack_o || icpu_err_o)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_entry actual=%0h required=none",
                             {icpu_adr_o, icpu_dat_o, icpu_err_o, icpu_tag_o});
                end else begin
                    e = exp_q.pop_front();
                    if ({icpu_adr_o, icpu_dat_o, icpu_err_o, icpu_tag_o, icpu_ack_o} !== {e, ~e[4]}) begin
                        bad++;
                        $display("FAIL entry actual=%0h/%0b required=%0h/%0b",
                                 {icpu_adr_o, icpu_dat_o, icpu_err_o, icpu_tag_o}, icpu_ack_o, e, ~e[4]);
                    end
                end
            end
        end
    end

    task automatic wait_out(input bit want_err, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #4;
            if (want_err ? icpu_err_o : icpu_ack_o) seen = 1'b1;
        end
    endtask

    initial begin
        int g;
        bit seen;

        // Reset and sequential streaming
        repeat (3) @(negedge clk);
        #4; chk("req_in_reset", ic_req_o, 0);
        @(negedge clk); rst = 1'b1; ic_gnt_i = 1'b1; rsp_en = 1'b1;
        #4;
        chk("rst_req", ic_req_o, 1);
        chk("rst_ic_adr", ic_adr_o, 32'h100);
        chk("rst_icpu_adr", icpu_adr_o, 32'h100);
        chk("rst_dat", icpu_dat_o, IFQ_NOP);
        chk("rst_tag", icpu_tag_o, ITAG_IDLE);
        chk("rst_ack", icpu_ack_o, 0);
        chk("rst_err", icpu_err_o, 0);
        @(negedge clk); #4;
        chk("seq_adr_104", ic_adr_o, 32'h104);
`ifdef OR1200_IFQ_BYPASS_EN
        chk("bypass_ack", icpu_ack_o, 1);
        chk("bypass_adr", icpu_adr_o, 32'h100);
`else
        chk("latency_no_ack", icpu_ack_o, 0);
`endif
        @(negedge clk); #4;
        chk("seq_adr_108", ic_adr_o, 32'h108);
        chk("first_ack", icpu_ack_o, 1);
`ifdef OR1200_IFQ_BYPASS_EN
        chk("first_adr", icpu_adr_o, 32'h104);
`else
        chk("first_adr", icpu_adr_o, 32'h100);
`endif
        repeat (5) @(negedge clk);

        // Freeze fill: credit limit stops requests at DEPTH
        if_freeze = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h1003;
        #4; chk("redirect_req_low", ic_req_o, 0);
        @(negedge clk); redirect_i = 1'b0; g = 0;
        repeat (8) begin #4; if (ic_req_o && ic_gnt_i) g++; @(negedge clk); end
        #4;
        chk("freeze_grants", g, 4);
        chk("full_req_low", ic_req_o, 0);
        chk("full_head_adr", icpu_adr_o, 32'h1000);
        chk("full_head_dat", icpu_dat_o, mem_word(32'h1000));
        @(negedge clk); #4;
        chk("full_stable_adr", icpu_adr_o, 32'h1000);
        chk("full_stable_req", ic_req_o, 0);
        @(negedge clk); if_freeze = 1'b0;
        @(negedge clk); #4;
        chk("req_resumes", ic_req_o, 1);
        repeat (6) @(negedge clk);

        // Two outstanding, then redirect to 0x2000
        ic_gnt_i = 1'b0;
        repeat (3) @(negedge clk);
        rsp_en = 1'b0; ic_gnt_i = 1'b1; g = 0;
        repeat (2) begin #4; if (ic_req_o && ic_gnt_i) g++; @(negedge clk); end
        chk("two_grants", g, 2);
        ic_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h2000;
        #4; chk("redirect2_req_low", ic_req_o, 0);
        @(negedge clk); redirect_i = 1'b0; ic_gnt_i = 1'b1; rsp_en = 1'b1;
        #4;
        chk("redir_ic_adr", ic_adr_o, 32'h2000);
        chk("redir_req", ic_req_o, 1);
        chk("redir_empty_ack", icpu_ack_o, 0);
        chk("redir_empty_adr", icpu_adr_o, 32'h2000);
        wait_out(1'b0, 10, seen);
        chk("redir_ack_seen", seen, 1);
        chk("redir_first_adr", icpu_adr_o, 32'h2000);

        // Error response at 0x108 halts fetching
        @(negedge clk); err_on = 1'b1; err_adr = 32'h108; redirect_i = 1'b1; redirect_pc_i = 32'h100;
        @(negedge clk); redirect_i = 1'b0;
        wait_out(1'b1, 12, seen);
        chk("err_seen", seen, 1);
        chk("err_tag", icpu_tag_o, ITAG_PE);
        chk("err_dat", icpu_dat_o, IFQ_NOP);
        chk("err_adr", icpu_adr_o, 32'h108);
        chk("err_no_ack", icpu_ack_o, 0);
        g = 0;
        repeat (6) begin @(negedge clk); #4; if (ic_req_o) g++; end
        chk("halt_no_req", g, 0);

        // Redirect coinciding with rvalid and grant, one stale response still in flight
        @(negedge clk); err_on = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h3000;
        @(negedge clk); redirect_i = 1'b0;
        repeat (4) @(negedge clk);
        rsp_en = 1'b0;
        @(negedge clk); rsp_en = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h4000;
        #4; chk("same_cycle_req_low", ic_req_o, 0);
        @(negedge clk); redirect_i = 1'b0;
        #4; chk("same_cycle_new_adr", ic_adr_o, 32'h4000);
        wait_out(1'b0, 10, seen);
        chk("same_cycle_ack_seen", seen, 1);
        chk("same_cycle_first_adr", icpu_adr_o, 32'h4000);
        chk("same_cycle_first_dat", icpu_dat_o, mem_word(32'h4000));

        // Reset with three entries queued
        @(negedge clk); if_freeze = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h5000;
        @(negedge clk); redirect_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #4; chk("midrst_req_low", ic_req_o, 0);
        @(negedge clk); rst = 1'b1; if_freeze = 1'b0;
        #4;
        chk("midrst_ic_adr", ic_adr_o, 32'h100);
        chk("midrst_req", ic_req_o, 1);
        chk("midrst_icpu_adr", icpu_adr_o, 32'h100);
        chk("midrst_ack", icpu_ack_o, 0);
        chk("midrst_err", icpu_err_o, 0);
        chk("midrst_dat", icpu_dat_o, IFQ_NOP);
        chk("midrst_tag", icpu_tag_o, ITAG_IDLE);
        repeat (5) @(negedge clk);
        ic_gnt_i = 1'b0;
        repeat (5) @(negedge clk);
        #4; chk("all_consumed", exp_q.size(), 0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
